sng_scheduler: RTL

Controller that owns the shared 16-bit LFSR random-number source and sequences stochastic-number-generation windows for the inference datapath. On `start` it seeds the LFSR through its `seed_set` input and waits for the LFSR outputs to settle. It then hands the per-cycle random pair (`n1`, `n2`) to up to NREQ requesters (SNG/comparator lanes) under rotating-priority arbitration until STREAM_LEN numbers have been issued. It sits between the LFSR instance and the stochastic-encoder lanes.

---
 rtl/sng_scheduler.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/sng_scheduler.sv
// Stochastic-number-generation window scheduler: seeds the shared LFSR, waits for it to settle,
// then hands LFSR random pairs to requesting lanes with rotating priority. Optional macro: SNG_SCHED_PAIR_EN.
module sng_scheduler #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned STREAM_LEN = 256,
    parameter int unsigned CNT_W      = 9,
    parameter int unsigned WARM_CYC   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [NREQ-1:0]  req,
    input  logic [7:0]       lfsr_n1,
    input  logic [7:0]       lfsr_n2,
    output logic             lfsr_seed_set,
    output logic [NREQ-1:0]  grant_a,
    output logic [NREQ-1:0]  grant_b,
    output logic [7:0]       rnd_a,
    output logic [7:0]       rnd_b,
    output logic             rnd_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] gen_cnt
);
    localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WARM_W = $clog2(WARM_CYC);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEED = 3'd1,
        ST_WARM = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end else begin
            sum = sum;
        end
        return sum[PTR_W-1:0];
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t            state_r, state_s;
    logic [WARM_W-1:0] warm_r, warm_s;
    logic [PTR_W-1:0]  ptr_r, ptr_s;
    logic [CNT_W-1:0]  gen_cnt_r, gen_cnt_s;
    logic              seed_r, seed_s;
    logic [NREQ-1:0]   grant_a_r, grant_a_s;
    logic [NREQ-1:0]   grant_b_r, grant_b_s;
    logic [7:0]        rnd_a_r, rnd_a_s, rnd_b_r, rnd_b_s;
    logic              valid_r, valid_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              found_a_s, found_b_s, use_b_s;
    logic [PTR_W-1:0]  win_a_s, win_b_s;

    // Rotating-priority search: primary winner from the pointer, secondary from just past it
    always_comb begin
        found_a_s = 1'b0;
        win_a_s   = '0;
        found_b_s = 1'b0;
        win_b_s   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found_a_s && req[wrap_idx(ptr_r, i)]) begin
                found_a_s = 1'b1;
                win_a_s   = wrap_idx(ptr_r, i);
            end else begin
                found_a_s = found_a_s;
            end
        end
`ifdef SNG_SCHED_PAIR_EN
        for (int unsigned j = 1; j < NREQ; j++) begin
            if (found_a_s && !found_b_s && req[wrap_idx(win_a_s, j)]) begin
                found_b_s = 1'b1;
                win_b_s   = wrap_idx(win_a_s, j);
            end else begin
                found_b_s = found_b_s;
            end
        end
`endif
        // The final number of a window can only go to one lane
        use_b_s = found_b_s && (gen_cnt_r != CNT_W'(STREAM_LEN - 1));
    end

    // Next-state and next-output logic; every output below is registered
    always_comb begin
        state_s   = state_r;
        warm_s    = warm_r;
        ptr_s     = ptr_r;
        gen_cnt_s = gen_cnt_r;
        grant_a_s = '0;
        grant_b_s = '0;
        rnd_a_s   = 8'd0;
        rnd_b_s   = 8'd0;
        valid_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s   = ST_SEED;
                    gen_cnt_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEED: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WARM;
                    warm_s  = '0;
                end
            end
            ST_WARM: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    warm_s  = '0;
                end else if (warm_r == WARM_W'(WARM_CYC - 1)) begin
                    state_s = ST_RUN;
                    warm_s  = '0;
                end else begin
                    warm_s = warm_r + WARM_W'(1);
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (gen_cnt_r == CNT_W'(STREAM_LEN)) begin
                    state_s = ST_DONE;
                end else if (found_a_s) begin
                    grant_a_s = onehot(win_a_s);
                    rnd_a_s   = lfsr_n1;
                    valid_s   = 1'b1;
`ifdef SNG_SCHED_PAIR_EN
                    if (use_b_s) begin
                        grant_b_s = onehot(win_b_s);
                        rnd_b_s   = lfsr_n2;
                        ptr_s     = wrap_idx(win_b_s, 1);
                        gen_cnt_s = gen_cnt_r + CNT_W'(2);
                    end else begin
                        ptr_s     = wrap_idx(win_a_s, 1);
                        gen_cnt_s = gen_cnt_r + CNT_W'(1);
                    end
`else
                    rnd_b_s   = lfsr_n2;
                    ptr_s     = wrap_idx(win_a_s, 1);
                    gen_cnt_s = gen_cnt_r + CNT_W'(1);
`endif
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        seed_s = (state_s == ST_SEED);
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            warm_r    <= '0;
            ptr_r     <= '0;
            gen_cnt_r <= '0;
            seed_r    <= 1'b0;
            grant_a_r <= '0;
            grant_b_r <= '0;
            rnd_a_r   <= 8'd0;
            rnd_b_r   <= 8'd0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            warm_r    <= warm_s;
            ptr_r     <= ptr_s;
            gen_cnt_r <= gen_cnt_s;
            seed_r    <= seed_s;
            grant_a_r <= grant_a_s;
            grant_b_r <= grant_b_s;
            rnd_a_r   <= rnd_a_s;
            rnd_b_r   <= rnd_b_s;
            valid_r   <= valid_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign lfsr_seed_set = seed_r;
    assign grant_a       = grant_a_r;
`ifdef SNG_SCHED_PAIR_EN
    assign grant_b       = grant_b_r;
`else
    assign grant_b       = grant_b_r & '0;
`endif
    assign rnd_a         = rnd_a_r;
    assign rnd_b         = rnd_b_r;
    assign rnd_valid     = valid_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign gen_cnt       = gen_cnt_r;

endmodule
